multicycle_main_fsm: RTL and testbench
======================================

Name: multicycle_main_fsm

Overview:
Main control unit for the multi-cycle RV32I core, replacing the combinational single-cycle main decoder. It is a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles, and drives the shared-ALU/shared-memory datapath muxes and write strobes. Compared with the single-cycle decoder it adds JAL, LUI, BNE, a memory wait-state handshake and an illegal-opcode trap.

Parameters:
MEM_WAIT_EN, 1, 1 = FETCH/MEMREAD/MEMWRITE stall until mem_ready; 0 = mem_ready ignored (treated as 1)
ENABLE_JAL, 1, 1 = op 1101111 supported; 0 = treated as illegal
ENABLE_LUI, 1, 1 = op 0110111 supported; 0 = treated as illegal

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
op  input  7  opcode from instruction register, stable from DECODE until return to FETCH
funct3  input  3  instr[14:12] from instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  unified memory access complete this cycle
pc_write  output  1  PC register enable
adr_src  output  1  memory address mux: 0 = PC, 1 = ALUOut
mem_write  output  1  memory write strobe
ir_write  output  1  IR/OldPC load enable
reg_write  output  1  register file write enable
result_src  output  2  00 = ALUOut, 01 = mem data, 10 = ALU result
alu_src_a  output  2  00 = PC, 01 = OldPC, 10 = rs1, 11 = constant zero
alu_src_b  output  2  00 = rs2, 01 = immediate, 10 = constant 4
alu_op  output  2  00 = add, 01 = subtract (branch), 10 = use funct3/funct7
imm_src  output  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
illegal  output  1  sticky illegal-instruction flag
state  output  4  current state encoding (debug)

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BRANCH=10, LUI=11, ILLEGAL=15.
- Reset (rst_n=0, asynchronous): state=FETCH, illegal=0. While reset is asserted, pc_write, ir_write, mem_write and reg_write are forced to 0. All other outputs take their FETCH values.
- rdy = mem_ready when MEM_WAIT_EN=1, otherwise 1.
- Unlisted outputs default to 0. pc_write = pc_update | (branch & taken).
- FETCH: adr_src=0, src_a=00, src_b=10, alu_op=00, result_src=10, ir_write=rdy, pc_update=rdy. Goes to DECODE if rdy, else holds.
- DECODE: src_a=01, src_b=01, alu_op=00 (computes branch target into ALUOut). Next state by op:
  - 0000011/0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH if funct3 is 000 or 001, else ILLEGAL
  - 1101111 -> JAL (if ENABLE_JAL)
  - 0110111 -> LUI (if ENABLE_LUI)
  - anything else -> ILLEGAL
- MEMADR: src_a=10, src_b=01, alu_op=00. Goes to MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Goes to MEMWB if rdy, else holds.
- MEMWB: result_src=01, reg_write=1. Goes to FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1, held high every cycle until rdy. Goes to FETCH if rdy, else holds.
- EXECR: src_a=10, src_b=00, alu_op=10. Goes to ALUWB.
- EXECI: src_a=10, src_b=01, alu_op=10. Goes to ALUWB.
- ALUWB: result_src=00, reg_write=1. Goes to FETCH.
- JAL: src_a=01, src_b=10, alu_op=00, result_src=00, pc_update=1 (PC <- jump target held in ALUOut; ALU computes OldPC+4). Goes to ALUWB.
- LUI: src_a=11, src_b=01, alu_op=00. Goes to ALUWB.
- BRANCH: src_a=10, src_b=00, alu_op=01, result_src=00, branch=1. taken = zero XOR funct3[0] (BEQ/BNE). Goes to FETCH.
- ILLEGAL: all strobes 0, illegal=1. The state is absorbing; only reset exits it.
- imm_src is decoded combinationally from op in every state: 0100011 -> 001, 1100011 -> 010, 1101111 -> 011, 0110111 -> 100, otherwise 000.
- Cycle counts with rdy=1 every cycle: R/I = 4, lw = 5, sw = 4, branch = 3, jal = 4, lui = 4. Each stall cycle adds exactly one cycle.
- Reset asserted mid-instruction returns to FETCH in the same cycle. No write strobe is asserted on the first post-reset edge unless FETCH with rdy=1.

Test Plan:
- Reset released, MEM_WAIT_EN=1, op=0000011, mem_ready low for 2 cycles in FETCH and 2 cycles in MEMREAD -> state sequence 0,0,0,1,2,3,3,3,4,0. ir_write and pc_write pulse only on the rdy cycle. reg_write=1 with result_src=01 only in state 4.
- op=1100011, funct3=001, zero=0 -> BRANCH with alu_op=01 and pc_write=1. Same instruction with zero=1 -> pc_write=0. funct3=000 with zero=1 -> pc_write=1.
- op=0100011, mem_ready low 3 cycles in MEMWRITE -> mem_write=1 and adr_src=1 for 4 consecutive cycles, imm_src=001, then FETCH.
- op=1101111, ENABLE_JAL=1 -> states 0,1,9,7,0. pc_write=1 in states 0 and 9; reg_write=1 in state 7; imm_src=011. Repeat with ENABLE_JAL=0 -> state 15, illegal=1, held through 10 further cycles with all strobes 0.
- op=0110111 -> states 0,1,11,7,0 with alu_src_a=11 and imm_src=100. op=1111111 -> illegal=1.
- rst_n pulsed low in MEMWRITE while mem_write=1 -> mem_write drops immediately (asynchronous), state=0. After release, a normal 4-cycle R-type (op=0110011) completes.

Source files
------------

// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the multi-cycle main FSM and the shared-ALU/shared-memory datapath.
// master = controller side (drives strobes/mux selects), slave = datapath side (drives decode fields/flags).
interface multicycle_main_fsm_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [2:0] imm_src;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct3, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal, state
  );

  modport slave (
    output op, funct3, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal, state
  );
endinterface

// File: rtl/multicycle_main_fsm.sv
// Moore main control FSM for the multi-cycle RV32I core: 3-5 cycles per instruction.
// FETCH/MEMREAD/MEMWRITE stall on mem_ready (when MEM_WAIT_EN); unknown opcodes trap into an absorbing ILLEGAL state.
module multicycle_main_fsm #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter bit ENABLE_JAL  = 1'b1,
  parameter bit ENABLE_LUI  = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  multicycle_main_fsm_if.master       bus
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_LUI      = 4'd11,
    S_ILLEGAL  = 4'd15
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       rdy;
  logic       taken;

  logic       pc_update;
  logic       branch;
  logic       ir_write_raw;
  logic       mem_write_raw;
  logic       reg_write_raw;
  logic       adr_src;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       illegal;
  logic [2:0] imm_src;

  assign rdy   = MEM_WAIT_EN ? bus.mem_ready : 1'b1;
  // funct3[0] distinguishes BNE from BEQ, so it inverts the zero sense
  assign taken = bus.zero ^ bus.funct3[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (bus.op)
          OP_LOAD,
          OP_STORE:  state_d = S_MEMADR;
          OP_RTYPE:  state_d = S_EXECR;
          OP_ITYPE:  state_d = S_EXECI;
          OP_BRANCH: state_d = (bus.funct3 == 3'b000 || bus.funct3 == 3'b001) ? S_BRANCH : S_ILLEGAL;
          OP_JAL:    state_d = ENABLE_JAL ? S_JAL : S_ILLEGAL;
          OP_LUI:    state_d = ENABLE_LUI ? S_LUI : S_ILLEGAL;
          default:   state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = rdy ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_LUI:      state_d = S_ALUWB;
      S_BRANCH:   state_d = S_FETCH;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_ILLEGAL;
    endcase
  end

  always_comb begin
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    adr_src       = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    illegal       = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        ir_write_raw = rdy;
        pc_update    = rdy;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
      end
      // strobe held for the whole stall so the memory sees a stable request
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_STORE:  imm_src = 3'b001;
      OP_BRANCH: imm_src = 3'b010;
      OP_JAL:    imm_src = 3'b011;
      OP_LUI:    imm_src = 3'b100;
      default:   imm_src = 3'b000;
    endcase
  end

  // write strobes are gated by rst_n so an async reset kills them immediately
  assign bus.pc_write   = rst_n & (pc_update | (branch & taken));
  assign bus.ir_write   = rst_n & ir_write_raw;
  assign bus.mem_write  = rst_n & mem_write_raw;
  assign bus.reg_write  = rst_n & reg_write_raw;
  assign bus.adr_src    = adr_src;
  assign bus.result_src = result_src;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.imm_src    = imm_src;
  assign bus.illegal    = illegal;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed vector table plus hand-written sequences for async reset and the JAL-disabled/no-wait variant.
module tb_multicycle_main_fsm;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] LU  = 7'b0110111;
  localparam logic [6:0] BAD = 7'b1111111;

  logic clk;
  logic rst_n;
  logic rst2_n;

  multicycle_main_fsm_if bus ();
  multicycle_main_fsm_if bus2 ();

  multicycle_main_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  multicycle_main_fsm #(
    .MEM_WAIT_EN (1'b0),
    .ENABLE_JAL  (1'b0),
    .ENABLE_LUI  (1'b1)
  ) dut2 (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        z;
    logic        rdy;
    logic [20:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  // expected word: {state, pc_write, ir_write, reg_write, mem_write, adr_src, result_src, src_a, src_b, alu_op, imm_src, illegal}
  function automatic vec_t mk(input int rst, input logic [6:0] op, input int f3, input int z, input int rdy,
                              input int st, input int pcw, input int irw, input int rw, input int mw, input int adr,
                              input int rs, input int sa, input int sb, input int ao, input int imm, input int ill);
    vec_t v;
    v.rst = 1'(rst);
    v.op  = op;
    v.f3  = 3'(f3);
    v.z   = 1'(z);
    v.rdy = 1'(rdy);
    v.exp = {4'(st), 1'(pcw), 1'(irw), 1'(rw), 1'(mw), 1'(adr),
             2'(rs), 2'(sa), 2'(sb), 2'(ao), 3'(imm), 1'(ill)};
    return v;
  endfunction

  function automatic logic [20:0] actual1();
    return {bus.state, bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write, bus.adr_src,
            bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.imm_src, bus.illegal};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] seq;
    int          n;

    rst_n = 1'b0;
    rst2_n = 1'b0;
    bus.op = LW; bus.funct3 = 3'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    bus2.op = JL; bus2.funct3 = 3'd0; bus2.zero = 1'b0; bus2.mem_ready = 1'b0;

    // lw: 2 FETCH stalls, 2 MEMREAD stalls
    tbl.push_back(mk(0,LW,0,0,1,  0, 0,0,0,0,0, 2,0,2,0,0,0));
    tbl.push_back(mk(1,LW,0,0,0,  0, 0,0,0,0,0, 2,0,2,0,0,0));
    tbl.push_back(mk(1,LW,0,0,0,  0, 0,0,0,0,0, 2,0,2,0,0,0));
    tbl.push_back(mk(1,LW,0,0,1,  0, 1,1,0,0,0, 2,0,2,0,0,0));
    tbl.push_back(mk(1,LW,0,0,1,  1, 0,0,0,0,0, 0,1,1,0,0,0));
    tbl.push_back(mk(1,LW,0,0,1,  2, 0,0,0,0,0, 0,2,1,0,0,0));
    tbl.push_back(mk(1,LW,0,0,0,  3, 0,0,0,0,1, 0,0,0,0,0,0));
    tbl.push_back(mk(1,LW,0,0,0,  3, 0,0,0,0,1, 0,0,0,0,0,0));
    tbl.push_back(mk(1,LW,0,0,1,  3, 0,0,0,0,1, 0,0,0,0,0,0));
    tbl.push_back(mk(1,LW,0,0,1,  4, 0,0,1,0,0, 1,0,0,0,0,0));
    // BNE zero=0 taken, BNE zero=1 not taken, BEQ zero=1 taken, BEQ zero=0 not taken
    for (int b = 0; b < 4; b++) begin
      int f3;
      int z;
      int tk;
      f3 = (b < 2) ? 1 : 0;
      z  = (b == 0 || b == 3) ? 0 : 1;
      tk = (b == 0 || b == 2) ? 1 : 0;
      tbl.push_back(mk(1,BR,f3,z,1,  0, 1,1,0,0,0, 2,0,2,0,2,0));
      tbl.push_back(mk(1,BR,f3,z,1,  1, 0,0,0,0,0, 0,1,1,0,2,0));
      tbl.push_back(mk(1,BR,f3,z,1, 10, tk,0,0,0,0, 0,2,0,1,2,0));
    end
    // sw with 3 MEMWRITE stalls
    tbl.push_back(mk(1,SW,0,0,1,  0, 1,1,0,0,0, 2,0,2,0,1,0));
    tbl.push_back(mk(1,SW,0,0,1,  1, 0,0,0,0,0, 0,1,1,0,1,0));
    tbl.push_back(mk(1,SW,0,0,1,  2, 0,0,0,0,0, 0,2,1,0,1,0));
    tbl.push_back(mk(1,SW,0,0,0,  5, 0,0,0,1,1, 0,0,0,0,1,0));
    tbl.push_back(mk(1,SW,0,0,0,  5, 0,0,0,1,1, 0,0,0,0,1,0));
    tbl.push_back(mk(1,SW,0,0,0,  5, 0,0,0,1,1, 0,0,0,0,1,0));
    tbl.push_back(mk(1,SW,0,0,1,  5, 0,0,0,1,1, 0,0,0,0,1,0));
    // jal
    tbl.push_back(mk(1,JL,0,0,1,  0, 1,1,0,0,0, 2,0,2,0,3,0));
    tbl.push_back(mk(1,JL,0,0,1,  1, 0,0,0,0,0, 0,1,1,0,3,0));
    tbl.push_back(mk(1,JL,0,0,1,  9, 1,0,0,0,0, 0,1,2,0,3,0));
    tbl.push_back(mk(1,JL,0,0,1,  7, 0,0,1,0,0, 0,0,0,0,3,0));
    // lui
    tbl.push_back(mk(1,LU,0,0,1,  0, 1,1,0,0,0, 2,0,2,0,4,0));
    tbl.push_back(mk(1,LU,0,0,1,  1, 0,0,0,0,0, 0,1,1,0,4,0));
    tbl.push_back(mk(1,LU,0,0,1, 11, 0,0,0,0,0, 0,3,1,0,4,0));
    tbl.push_back(mk(1,LU,0,0,1,  7, 0,0,1,0,0, 0,0,0,0,4,0));
    // R-type and I-type
    tbl.push_back(mk(1,RT,7,0,1,  0, 1,1,0,0,0, 2,0,2,0,0,0));
    tbl.push_back(mk(1,RT,7,0,1,  1, 0,0,0,0,0, 0,1,1,0,0,0));
    tbl.push_back(mk(1,RT,7,0,1,  6, 0,0,0,0,0, 0,2,0,2,0,0));
    tbl.push_back(mk(1,RT,7,0,1,  7, 0,0,1,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,IT,2,0,1,  0, 1,1,0,0,0, 2,0,2,0,0,0));
    tbl.push_back(mk(1,IT,2,0,1,  1, 0,0,0,0,0, 0,1,1,0,0,0));
    tbl.push_back(mk(1,IT,2,0,1,  8, 0,0,0,0,0, 0,2,1,2,0,0));
    tbl.push_back(mk(1,IT,2,0,1,  7, 0,0,1,0,0, 0,0,0,0,0,0));
    // unknown opcode traps and stays trapped
    tbl.push_back(mk(1,BAD,0,0,1, 0, 1,1,0,0,0, 2,0,2,0,0,0));
    tbl.push_back(mk(1,BAD,0,0,1, 1, 0,0,0,0,0, 0,1,1,0,0,0));
    tbl.push_back(mk(1,BAD,0,1,0,15, 0,0,0,0,0, 0,0,0,0,0,1));
    tbl.push_back(mk(1,BAD,0,1,1,15, 0,0,0,0,0, 0,0,0,0,0,1));
    tbl.push_back(mk(1,BAD,0,0,1,15, 0,0,0,0,0, 0,0,0,0,0,1));
    // reset exits ILLEGAL; branch with unsupported funct3 traps
    tbl.push_back(mk(0,BR,2,0,1,  0, 0,0,0,0,0, 2,0,2,0,2,0));
    tbl.push_back(mk(1,BR,2,0,1,  0, 1,1,0,0,0, 2,0,2,0,2,0));
    tbl.push_back(mk(1,BR,2,0,1,  1, 0,0,0,0,0, 0,1,1,0,2,0));
    tbl.push_back(mk(1,BR,2,1,1, 15, 0,0,0,0,0, 0,0,0,0,2,1));
    tbl.push_back(mk(1,BR,2,0,1, 15, 0,0,0,0,0, 0,0,0,0,2,1));
    tbl.push_back(mk(0,RT,0,0,1,  0, 0,0,0,0,0, 2,0,2,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_n = tbl[i].rst;
      bus.op = tbl[i].op;
      bus.funct3 = tbl[i].f3;
      bus.zero = tbl[i].z;
      bus.mem_ready = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d", i), 32'(actual1()), 32'(tbl[i].exp));
    end

    // async reset while mem_write is high in MEMWRITE
    @(negedge clk); rst_n = 1'b1; bus.op = SW; bus.funct3 = 3'd0; bus.mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); bus.mem_ready = 1'b0;
    #1;
    chk("memwrite_before_reset", {27'd0, bus.state, bus.mem_write}, {27'd0, 4'd5, 1'b1});
    #2;
    rst_n = 1'b0;
    #1;
    chk("memwrite_async_reset", {26'd0, bus.state, bus.mem_write, bus.adr_src}, 32'd0);
    @(negedge clk); rst_n = 1'b1; bus.op = RT; bus.mem_ready = 1'b1;
    #1;
    chk("rtype_start_fetch", {28'd0, bus.state}, 32'd0);
    seq = 16'd0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      seq = {seq[11:0], bus.state};
      n++;
      if (bus.state == 4'd0) break;
    end
    chk("rtype_cycle_count", 32'(n), 32'd4);
    chk("rtype_state_seq", {16'd0, seq}, 32'h0000_1670);

    // JAL disabled, memory wait ignored
    @(negedge clk); bus2.op = JL; bus2.mem_ready = 1'b0;
    #1;
    chk("nj_reset_strobes", {28'd0, bus2.pc_write, bus2.ir_write, bus2.reg_write, bus2.mem_write}, 32'd0);
    @(negedge clk); rst2_n = 1'b1;
    #1;
    chk("nj_fetch_ignores_ready", {26'd0, bus2.state, bus2.pc_write, bus2.ir_write}, {26'd0, 4'd0, 2'b11});
    @(negedge clk); #1;
    chk("nj_decode", {28'd0, bus2.state}, 32'd1);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      bus2.mem_ready = 1'(k);
      #1;
      chk($sformatf("nj_illegal_hold%0d", k),
          {23'd0, bus2.state, bus2.illegal, bus2.pc_write, bus2.ir_write, bus2.reg_write, bus2.mem_write},
          {23'd0, 4'd15, 1'b1, 4'b0000});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
